// File: rtl/dvp_ctrl_pkg.sv
// Shared encodings for the DVP capture sequencer: FSM states, colour modes, header marker.
// The HDR0/HDR1 states exist only when FRAME_HDR_EN is defined.
package dvp_ctrl_pkg;

    localparam int          COLOR_MODE_GRAY   = 1;
    localparam int          COLOR_MODE_RGB565 = 2;
    localparam logic [15:0] DEFAULT_HDR_WORD  = 16'hA5A5;

`ifdef FRAME_HDR_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_HDR0    = 3'd2,
        ST_HDR1    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DROP    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CAPTURE = 3'd4,
        ST_DROP    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;
`endif

    // Grayscale carries one byte per pixel, RGB565 two.
    function automatic logic [15:0] line_bytes(input int mode, input int h_res);
        return (mode == COLOR_MODE_GRAY) ? 16'(h_res) : 16'(2 * h_res);
    endfunction

endpackage

// File: rtl/dvp_capture_ctrl_if.sv
// Camera-pin and write-FIFO signal bundle of the DVP capture sequencer.
// The slave modport is the sequencer's view; master is the camera/FIFO side.
interface dvp_capture_ctrl_if;

    logic        VSYNC_cam;
    logic        HREF_cam;
    logic [7:0]  data_cam;
    logic        fifo_full;
    logic [15:0] fifo_data;
    logic        fifo_wr;

    modport master (
        output VSYNC_cam, HREF_cam, data_cam, fifo_full,
        input  fifo_data, fifo_wr
    );

    modport slave (
        input  VSYNC_cam, HREF_cam, data_cam, fifo_full,
        output fifo_data, fifo_wr
    );

endinterface

// File: rtl/dvp_byte_packer.sv
// Pairs camera bytes into 16-bit words (first byte high) and tracks the byte count of the
// current line; line_bad is meaningful on the cycle HREF has just fallen.
module dvp_byte_packer
    import dvp_ctrl_pkg::*;
#(
    parameter logic [15:0] LINE_BYTES = line_bytes(COLOR_MODE_RGB565, 640)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        active,
    input  logic        href,
    input  logic        href_rise,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [15:0] word,
    output logic        line_bad
);

    logic        phase;
    logic        cur_phase;
    logic [7:0]  hi_byte;
    logic [15:0] byte_cnt;

    // The first byte of every line is forced to phase 0 regardless of leftovers.
    assign cur_phase  = href_rise ? 1'b0 : phase;
    assign word_valid = active & href & cur_phase;
    assign word       = {hi_byte, data};
    assign line_bad   = (byte_cnt != LINE_BYTES) | phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= 1'b0;
            hi_byte  <= 8'h00;
            byte_cnt <= 16'd0;
        end else if (!active) begin
            phase    <= 1'b0;
            byte_cnt <= 16'd0;
        end else if (href) begin
            phase    <= ~cur_phase;
            byte_cnt <= href_rise ? 16'd1 : byte_cnt + 16'd1;
            if (!cur_phase) begin
                hi_byte <= data;
            end
        end
    end

endmodule

// File: rtl/dvp_capture_ctrl.sv
// Frame-capture sequencer from the DVP camera port to the write FIFO, clocked by PCLK_cam.
// Optional FRAME_HDR_EN prefixes each frame with HDR_WORD and {8'h00, frame_cnt}.
module dvp_capture_ctrl
    import dvp_ctrl_pkg::*;
#(
    parameter int          COLOR_MODE = COLOR_MODE_RGB565,
    parameter int          H_RES      = 640,
    parameter int          V_RES      = 480,
    parameter logic [15:0] HDR_WORD   = DEFAULT_HDR_WORD
) (
    input  logic              PCLK_cam,
    input  logic              rst,
    input  logic              cap_start,
    input  logic              cap_cont,
    input  logic              cap_stop,
    dvp_capture_ctrl_if.slave bus,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic              ovf,
    output logic [7:0]        frame_cnt
);

    localparam logic [15:0] LINE_BYTES = line_bytes(COLOR_MODE, H_RES);
    localparam logic [15:0] LAST_LINE  = 16'(V_RES);

    state_t      state, state_next;
    logic        vs_r, vs_d, href_r, href_d;
    logic [7:0]  data_r;
    logic        vsync_rise, vsync_fall, href_rise, href_fall;
    logic        word_valid, line_bad;
    logic [15:0] word;
    logic        wr_q, wr_next;
    logic [15:0] data_q, data_next;
    logic        overflow, err_set, err_flag;
    logic [15:0] line_cnt;

`ifndef FRAME_HDR_EN
    logic unused_hdr;
    assign unused_hdr = ^HDR_WORD;
`endif

    always_ff @(posedge PCLK_cam or posedge rst) begin
        if (rst) begin
            vs_r   <= 1'b0;
            vs_d   <= 1'b0;
            href_r <= 1'b0;
            href_d <= 1'b0;
            data_r <= 8'h00;
        end else begin
            vs_r   <= bus.VSYNC_cam;
            vs_d   <= vs_r;
            href_r <= bus.HREF_cam;
            href_d <= href_r;
            data_r <= bus.data_cam;
        end
    end

    assign vsync_rise = vs_r & ~vs_d;
    assign vsync_fall = ~vs_r & vs_d;
    assign href_rise  = href_r & ~href_d;
    assign href_fall  = ~href_r & href_d;

    dvp_byte_packer #(.LINE_BYTES(LINE_BYTES)) u_packer (
        .clk        (PCLK_cam),
        .rst        (rst),
        .active     (state == ST_CAPTURE),
        .href       (href_r),
        .href_rise  (href_rise),
        .data       (data_r),
        .word_valid (word_valid),
        .word       (word),
        .line_bad   (line_bad)
    );

    always_ff @(posedge PCLK_cam or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wr_next    = 1'b0;
        data_next  = data_q;
        overflow   = 1'b0;
        err_set    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cap_start) state_next = ST_ARM;
            end
            ST_ARM: begin
`ifdef FRAME_HDR_EN
                if (vsync_fall) state_next = ST_HDR0;
`else
                if (vsync_fall) state_next = ST_CAPTURE;
`endif
            end
`ifdef FRAME_HDR_EN
            // A line starting before both header words went out counts as an overflow.
            ST_HDR0: begin
                if (href_rise) begin
                    overflow   = 1'b1;
                    err_set    = 1'b1;
                    state_next = ST_DROP;
                end else if (!bus.fifo_full) begin
                    wr_next    = 1'b1;
                    data_next  = HDR_WORD;
                    state_next = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (href_rise) begin
                    overflow   = 1'b1;
                    err_set    = 1'b1;
                    state_next = ST_DROP;
                end else if (!bus.fifo_full) begin
                    wr_next    = 1'b1;
                    data_next  = {8'h00, frame_cnt};
                    state_next = ST_CAPTURE;
                end
            end
`endif
            ST_CAPTURE: begin
                if (word_valid && bus.fifo_full) begin
                    overflow   = 1'b1;
                    err_set    = 1'b1;
                    state_next = ST_DROP;
                end else if (word_valid) begin
                    wr_next   = 1'b1;
                    data_next = word;
                end else if (href_fall) begin
                    err_set = line_bad;
                    if (line_cnt + 16'd1 == LAST_LINE) state_next = ST_DONE;
                end else if (vsync_rise) begin
                    err_set    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DROP: begin
                if (vsync_rise) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = cap_cont ? ST_ARM : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (cap_stop) begin
            state_next = ST_IDLE;
            wr_next    = 1'b0;
            overflow   = 1'b0;
            err_set    = 1'b0;
        end
    end

    // frame_cnt advances on DONE entry so the new count is visible alongside frame_done.
    always_ff @(posedge PCLK_cam or posedge rst) begin
        if (rst) begin
            wr_q      <= 1'b0;
            data_q    <= 16'h0000;
            ovf       <= 1'b0;
            err_flag  <= 1'b0;
            line_cnt  <= 16'd0;
            frame_cnt <= 8'd0;
        end else begin
            wr_q   <= wr_next;
            data_q <= data_next;
            if (overflow) begin
                ovf <= 1'b1;
            end else if (cap_start) begin
                ovf <= 1'b0;
            end
            if (state == ST_ARM) begin
                err_flag <= 1'b0;
                line_cnt <= 16'd0;
            end else begin
                if (err_set) err_flag <= 1'b1;
                if (state == ST_CAPTURE && href_fall) line_cnt <= line_cnt + 16'd1;
            end
            if (state != ST_DONE && state_next == ST_DONE) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    assign busy          = (state != ST_IDLE);
    assign frame_done    = (state == ST_DONE);
    assign frame_err     = frame_done & err_flag;
    assign bus.fifo_wr   = wr_q;
    assign bus.fifo_data = data_q;

endmodule

// File: tb/tb_dvp_capture_ctrl.sv
// Scoreboard bench for dvp_capture_ctrl (RGB565, H_RES=4, V_RES=2); header checks under FRAME_HDR_EN.
// Stimulus pushes expected words and frame_done status; a negedge monitor pops and compares.
module tb_dvp_capture_ctrl;
    import dvp_ctrl_pkg::*;

    localparam int H_RES = 4;
    localparam int V_RES = 2;
    localparam int LINE_N = 2 * H_RES;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cap_start = 1'b0;
    logic       cap_cont = 1'b0;
    logic       cap_stop = 1'b0;
    logic       busy, frame_done, frame_err, ovf;
    logic [7:0] frame_cnt;

    dvp_capture_ctrl_if bus();

    dvp_capture_ctrl #(
        .COLOR_MODE (COLOR_MODE_RGB565),
        .H_RES      (H_RES),
        .V_RES      (V_RES),
        .HDR_WORD   (16'hA5A5)
    ) dut (
        .PCLK_cam   (clk),
        .rst        (rst),
        .cap_start  (cap_start),
        .cap_cont   (cap_cont),
        .cap_stop   (cap_stop),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .ovf        (ovf),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    logic [15:0] exp_words[$];
    logic [8:0]  exp_done[$];
    logic [7:0]  exp_cnt = 8'd0;
    logic        hold_full = 1'b0;
    logic [15:0] mon_word;
    logic [8:0]  mon_done;
    int          checks = 0;
    int          passes = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One PCLK cycle of camera/FIFO pin values, driven just after the rising edge.
    task automatic applyStimulus(input logic vs, input logic href, input logic [7:0] data, input logic full);
        @(posedge clk);
        #1;
        bus.VSYNC_cam = vs;
        bus.HREF_cam  = href;
        bus.data_cam  = data;
        bus.fifo_full = full;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 8'h00, hold_full);
    endtask

    task automatic ctrl_pulse(input logic start, input logic stop);
        @(posedge clk);
        #1;
        cap_start = start;
        cap_stop  = stop;
        @(posedge clk);
        #1;
        cap_start = 1'b0;
        cap_stop  = 1'b0;
    endtask

    task automatic vsync_pulse();
        repeat (4) applyStimulus(1'b1, 1'b0, 8'h00, hold_full);
        idle(6);
    endtask

    task automatic push_header();
`ifdef FRAME_HDR_EN
        exp_words.push_back(16'hA5A5);
        exp_words.push_back({8'h00, exp_cnt});
`endif
    endtask

    task automatic push_done(input logic err);
        exp_cnt = exp_cnt + 8'd1;
        exp_done.push_back({err, exp_cnt});
    endtask

    task automatic send_line(input int n, input logic [7:0] base, input bit expect_words,
                             input int full_idx, input int full_until);
        logic [7:0] b;
        logic [7:0] prev;
        prev = 8'h00;
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i);
            applyStimulus(1'b0, 1'b1, b, (i == full_idx) || (i < full_until));
            if (expect_words && i[0]) exp_words.push_back({prev, b});
            prev = b;
        end
        idle(4);
    endtask

    task automatic send_frame(input int n0, input int n1, input logic [7:0] base, input bit expect_frame);
        if (expect_frame) begin
            push_header();
            push_done((n0 != LINE_N) || (n1 != LINE_N));
        end
        vsync_pulse();
        send_line(n0, base, expect_frame, -1, 0);
        send_line(n1, base + 8'h40, expect_frame, -1, 0);
        idle(2);
    endtask

    task automatic check_drained(input string tag);
        checkOutput({tag, " words pending"}, 32'(exp_words.size()), 32'd0);
        checkOutput({tag, " done pending"}, 32'(exp_done.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.fifo_wr) begin
                if (exp_words.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL fifo_wr_unexpected: got word 0x%04h, expected no write", bus.fifo_data);
                end else begin
                    mon_word = exp_words.pop_front();
                    checkOutput("fifo_data", 32'(bus.fifo_data), 32'(mon_word));
                end
            end
            if (frame_done) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL frame_done_unexpected: got err=%0b cnt=%0d, expected no pulse", frame_err, frame_cnt);
                end else begin
                    mon_done = exp_done.pop_front();
                    checkOutput("frame_err", 32'(frame_err), 32'(mon_done[8]));
                    checkOutput("frame_cnt", 32'(frame_cnt), 32'(mon_done[7:0]));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.VSYNC_cam = 1'b0;
        bus.HREF_cam  = 1'b0;
        bus.data_cam  = 8'h00;
        bus.fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset frame_done", 32'(frame_done), 32'd0);
        checkOutput("reset ovf", 32'(ovf), 32'd0);
        checkOutput("reset frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("reset fifo_wr", 32'(bus.fifo_wr), 32'd0);
        rst = 1'b0;
        idle(3);

        $display("[TB] single frame capture");
        ctrl_pulse(1'b1, 1'b0);
        checkOutput("busy after start", 32'(busy), 32'd1);
        send_frame(LINE_N, LINE_N, 8'h10, 1'b1);
        idle(4);
        checkOutput("busy after frame", 32'(busy), 32'd0);
        check_drained("t1");

        $display("[TB] start mid-frame waits for next frame");
        vsync_pulse();
        ctrl_pulse(1'b1, 1'b0);
        send_line(LINE_N, 8'h20, 1'b0, -1, 0);
        send_line(LINE_N, 8'h28, 1'b0, -1, 0);
        idle(2);
        send_frame(LINE_N, LINE_N, 8'h30, 1'b1);
        idle(4);
        check_drained("t2");

        $display("[TB] one-cycle fifo_full overflow");
        ctrl_pulse(1'b1, 1'b0);
        push_header();
        exp_words.push_back(16'h5051);
        push_done(1'b1);
        vsync_pulse();
        send_line(LINE_N, 8'h50, 1'b0, 4, 0);
        send_line(LINE_N, 8'h90, 1'b0, -1, 0);
        idle(2);
        vsync_pulse();
        idle(4);
        checkOutput("ovf after overflow", 32'(ovf), 32'd1);
        checkOutput("busy after drop", 32'(busy), 32'd0);
        check_drained("t3");

        $display("[TB] odd-length line");
        ctrl_pulse(1'b1, 1'b0);
        checkOutput("ovf cleared by start", 32'(ovf), 32'd0);
        send_frame(LINE_N, LINE_N - 1, 8'h60, 1'b1);
        idle(4);
        check_drained("t4");

`ifdef FRAME_HDR_EN
        $display("[TB] frame header words");
        ctrl_pulse(1'b1, 1'b0);
        send_frame(LINE_N, LINE_N, 8'h70, 1'b1);
        idle(4);
        ctrl_pulse(1'b1, 1'b0);
        send_frame(LINE_N, LINE_N, 8'h78, 1'b1);
        idle(4);
        ctrl_pulse(1'b1, 1'b0);
        hold_full = 1'b1;
        push_done(1'b1);
        vsync_pulse();
        hold_full = 1'b0;
        send_line(LINE_N, 8'h80, 1'b0, -1, 2);
        send_line(LINE_N, 8'h88, 1'b0, -1, 0);
        idle(2);
        vsync_pulse();
        idle(4);
        checkOutput("ovf header overflow", 32'(ovf), 32'd1);
        check_drained("t6");
`endif

        $display("[TB] continuous capture through frame_cnt wrap");
        cap_cont = 1'b1;
        ctrl_pulse(1'b1, 1'b0);
        while (exp_cnt != 8'd254) send_frame(LINE_N, LINE_N, 8'(exp_cnt), 1'b1);
        checkOutput("frame_cnt before wrap", 32'(frame_cnt), 32'd254);
        repeat (3) send_frame(LINE_N, LINE_N, 8'hC0, 1'b1);
        checkOutput("frame_cnt after wrap", 32'(frame_cnt), 32'd1);
        push_header();
        vsync_pulse();
        send_line(LINE_N, 8'hE0, 1'b1, -1, 0);
        ctrl_pulse(1'b0, 1'b1);
        send_line(LINE_N, 8'hF0, 1'b0, -1, 0);
        idle(6);
        checkOutput("busy after stop", 32'(busy), 32'd0);
        checkOutput("frame_cnt after stop", 32'(frame_cnt), 32'd1);
        cap_cont = 1'b0;
        check_drained("t5");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
